// File: rtl/td4_prog_rom.sv
// TD4 program memory: registered fetch port plus an in-system loader that rewrites
// every word through a valid/ready stream. Reset restores the identity image.
module td4_prog_rom #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [ADDR_W-1:0] addr,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   input  logic              load_start,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   output logic              loading,
   output logic              load_done,
   output logic [ADDR_W-1:0] wr_ptr
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {RUN, LOAD} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              xfer, last, rd_fire;

   // A restart in the same cycle as a handshake drops that word.
   always_comb begin
      state_nxt = state;
      wr_ready  = 1'b0;
      loading   = 1'b0;
      xfer      = 1'b0;
      last      = 1'b0;
      rd_fire   = 1'b0;
      case (state)
         RUN: begin
            rd_fire = rd_en & ~load_start;
            if (load_start) state_nxt = LOAD;
         end
         LOAD: begin
            wr_ready = 1'b1;
            loading  = 1'b1;
            xfer     = wr_valid & ~load_start;
            last     = xfer & (wr_ptr == ADDR_W'(DEPTH - 1));
            if (last) state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= RUN;
         rdata     <= '0;
         rvalid    <= 1'b0;
         load_done <= 1'b0;
         wr_ptr    <= '0;
      end else begin
         state     <= state_nxt;
         rvalid    <= rd_fire;
         load_done <= last;
         if (rd_fire) rdata <= mem[addr];
         if (load_start)  wr_ptr <= '0;
         else if (xfer)   wr_ptr <= wr_ptr + ADDR_W'(1);
      end
   end

   // Identity image is the power-on program; truncated when DATA_W < ADDR_W.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(i);
      end else if (xfer) begin
         mem[wr_ptr] <= wr_data;
      end
   end

endmodule

// File: tb/tb_td4_prog_rom.sv
// Randomised bench for td4_prog_rom: default 8x16 instance plus a 12x8 instance,
// each checked against a plain array image of the expected memory contents.
module tb_td4_prog_rom;

   logic        clk, rst;
   logic [3:0]  a_addr, a_wr_ptr;
   logic        a_rd_en, a_rvalid, a_load_start, a_wr_valid, a_wr_ready, a_loading, a_load_done;
   logic [7:0]  a_rdata, a_wr_data;
   logic [2:0]  b_addr, b_wr_ptr;
   logic        b_rd_en, b_rvalid, b_load_start, b_wr_valid, b_wr_ready, b_loading, b_load_done;
   logic [11:0] b_rdata, b_wr_data;

   td4_prog_rom u_a (
      .CLK(clk), .RST(rst), .addr(a_addr), .rd_en(a_rd_en), .rdata(a_rdata), .rvalid(a_rvalid),
      .load_start(a_load_start), .wr_valid(a_wr_valid), .wr_data(a_wr_data), .wr_ready(a_wr_ready),
      .loading(a_loading), .load_done(a_load_done), .wr_ptr(a_wr_ptr));

   td4_prog_rom #(.DATA_W(12), .ADDR_W(3)) u_b (
      .CLK(clk), .RST(rst), .addr(b_addr), .rd_en(b_rd_en), .rdata(b_rdata), .rvalid(b_rvalid),
      .load_start(b_load_start), .wr_valid(b_wr_valid), .wr_data(b_wr_data), .wr_ready(b_wr_ready),
      .loading(b_loading), .load_done(b_load_done), .wr_ptr(b_wr_ptr));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0, errors = 0, done_cnt = 0;
   logic [7:0]  ma [16];
   logic [11:0] mb [8];
   logic [7:0]  exp_rd;

   always @(negedge clk) if (a_load_done === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      a_wr_valid = 1'b0; a_load_start = 1'b0; a_rd_en = 1'b0;
      b_wr_valid = 1'b0; b_load_start = 1'b0; b_rd_en = 1'b0;
      rst = 1'b0;
      #2;
      chk("rst_rdata",     32'(a_rdata), 0);
      chk("rst_rvalid",    32'(a_rvalid), 0);
      chk("rst_wr_ready",  32'(a_wr_ready), 0);
      chk("rst_loading",   32'(a_loading), 0);
      chk("rst_load_done", 32'(a_load_done), 0);
      chk("rst_wr_ptr",    32'(a_wr_ptr), 0);
      chk("rst_b_rdata",   32'(b_rdata), 0);
      chk("rst_b_loading", 32'(b_loading), 0);
      for (int i = 0; i < 16; i++) ma[i] = 8'(i);
      for (int i = 0; i < 8; i++) mb[i] = 12'(i);
      exp_rd = 8'h00;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic fetch(input int a);
      a_addr = 4'(a); a_rd_en = 1'b1;
      tick();
      exp_rd = ma[a];
      chk("fetch_rvalid", 32'(a_rvalid), 1);
      chk("fetch_rdata",  32'(a_rdata), 32'(exp_rd));
   endtask

   task automatic idle_chk();
      a_rd_en = 1'b0;
      tick();
      chk("idle_rvalid", 32'(a_rvalid), 0);
      chk("idle_rdata",  32'(a_rdata), 32'(exp_rd));
   endtask

   task automatic start_load();
      a_load_start = 1'b1; a_rd_en = 1'($urandom_range(0, 1)); a_addr = 4'($urandom);
      tick();
      a_load_start = 1'b0;
      chk("start_loading",  32'(a_loading), 1);
      chk("start_wr_ready", 32'(a_wr_ready), 1);
      chk("start_wr_ptr",   32'(a_wr_ptr), 0);
      chk("start_rvalid",   32'(a_rvalid), 0);
   endtask

   // base < 0 loads random words; mode 0 no gaps, 1 one gap per word, 2 random gaps
   task automatic feed(input int base, input int mode);
      int gaps, ra;
      logic [7:0] v;
      for (int i = 0; i < 16; i++) begin
         gaps = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
         for (int g = 0; g < gaps; g++) begin
            a_wr_valid = 1'b0; a_wr_data = 8'($urandom); a_rd_en = 1'($urandom_range(0, 1));
            tick();
            chk("gap_wr_ptr",    32'(a_wr_ptr), 32'(i));
            chk("gap_rvalid",    32'(a_rvalid), 0);
            chk("gap_load_done", 32'(a_load_done), 0);
         end
         v = (base < 0) ? 8'($urandom) : 8'(base + i);
         a_wr_valid = 1'b1; a_wr_data = v; a_rd_en = 1'($urandom_range(0, 1));
         tick();
         ma[i] = v;
         chk("word_rvalid", 32'(a_rvalid), 0);
         if (i < 15) chk("word_wr_ptr", 32'(a_wr_ptr), 32'(i + 1));
      end
      a_wr_valid = 1'b0;
      chk("done_pulse",   32'(a_load_done), 1);
      chk("done_loading", 32'(a_loading), 0);
      chk("done_wr_ptr",  32'(a_wr_ptr), 0);
      ra = int'($urandom_range(0, 15));
      fetch(ra);
      a_rd_en = 1'b0;
      chk("done_cleared", 32'(a_load_done), 0);
   endtask

   initial begin
      int d;
      logic [11:0] bv;
      rst = 1'b0;
      a_addr = '0; a_rd_en = 0; a_load_start = 0; a_wr_valid = 0; a_wr_data = '0;
      b_addr = '0; b_rd_en = 0; b_load_start = 0; b_wr_valid = 0; b_wr_data = '0;
      do_reset();

      // identity image, back-to-back fetches
      fetch(0); fetch(5); fetch(15);
      idle_chk();

      // full load with alternating gaps
      d = done_cnt;
      start_load();
      feed(8'hA0, 1);
      chk("a0_done_count", 32'(done_cnt - d), 1);
      for (int i = 0; i < 16; i++) fetch(i);
      idle_chk();

      // restart mid-load; the word accompanying the restart is dropped
      d = done_cnt;
      start_load();
      for (int i = 0; i < 3; i++) begin
         a_wr_valid = 1'b1; a_wr_data = 8'(8'h11 * (i + 1));
         tick();
         ma[i] = 8'(8'h11 * (i + 1));
      end
      a_load_start = 1'b1; a_wr_valid = 1'b1; a_wr_data = 8'h44;
      tick();
      a_load_start = 1'b0; a_wr_valid = 1'b0;
      chk("restart_wr_ptr",  32'(a_wr_ptr), 0);
      chk("restart_loading", 32'(a_loading), 1);
      feed(8'hC0, 0);
      chk("c0_done_count", 32'(done_cnt - d), 1);
      fetch(3);
      chk("restart_mem3", 32'(a_rdata), 32'h00C3);
      for (int i = 0; i < 16; i++) fetch(i);
      idle_chk();

      // reset in the middle of a load
      start_load();
      for (int i = 0; i < 5; i++) begin
         a_wr_valid = 1'b1; a_wr_data = 8'hFF;
         tick();
      end
      do_reset();
      fetch(2);
      chk("rst_mem2", 32'(a_rdata), 32'h02);
      for (int i = 0; i < 16; i++) fetch(i);
      idle_chk();

      // load_start beats rd_en; reads ignored in LOAD
      a_addr = 4'd7; a_rd_en = 1'b1; a_load_start = 1'b1;
      tick();
      a_load_start = 1'b0;
      chk("prio_rvalid",  32'(a_rvalid), 0);
      chk("prio_loading", 32'(a_loading), 1);
      chk("prio_rdata",   32'(a_rdata), 32'(exp_rd));
      tick();
      chk("load_rd_ignored", 32'(a_rvalid), 0);
      feed(-1, 2);
      for (int i = 0; i < 16; i++) fetch(i);
      idle_chk();

      // random loads followed by random read traffic
      repeat (4) begin
         d = done_cnt;
         start_load();
         feed(-1, 2);
         chk("rand_done_count", 32'(done_cnt - d), 1);
         repeat (30) begin
            a_rd_en = 1'($urandom_range(0, 1)); a_addr = 4'($urandom);
            tick();
            if (a_rd_en) exp_rd = ma[a_addr];
            chk("rand_rvalid", 32'(a_rvalid), 32'(a_rd_en));
            chk("rand_rdata",  32'(a_rdata), 32'(exp_rd));
         end
         a_rd_en = 1'b0;
      end

      // 12-bit x 8 instance
      for (int i = 0; i < 8; i++) begin
         b_addr = 3'(i); b_rd_en = 1'b1;
         tick();
         chk("b_default", 32'(b_rdata), 32'(mb[i]));
      end
      b_rd_en = 1'b0;
      b_load_start = 1'b1;
      tick();
      b_load_start = 1'b0;
      chk("b_loading", 32'(b_loading), 1);
      for (int i = 0; i < 8; i++) begin
         bv = (i == 5) ? 12'hABC : 12'($urandom);
         b_wr_valid = 1'b1; b_wr_data = bv;
         tick();
         mb[i] = bv;
         if (i < 7) chk("b_no_done", 32'(b_load_done), 0);
      end
      b_wr_valid = 1'b0;
      chk("b_done",      32'(b_load_done), 1);
      chk("b_wr_ptr",    32'(b_wr_ptr), 0);
      chk("b_load_over", 32'(b_loading), 0);
      for (int i = 0; i < 8; i++) begin
         b_addr = 3'(i); b_rd_en = 1'b1;
         tick();
         chk("b_readback", 32'(b_rdata), 32'(mb[i]));
         chk("b_rvalid",   32'(b_rvalid), 1);
      end
      b_rd_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
